serial_exec_unit: RTL and testbench
===================================

# serial_exec_unit

Bit-serial execution stage that sits directly downstream of the instruction-entry logic in the CPU top level. It accepts one 16-bit instruction (4-bit opcode plus 12-bit operand field) on a one-cycle start pulse. It evaluates the instruction LSB-first through a 1-bit ALU slice over 8 shift cycles, writes back to a 4×8-bit register file, and drives the 8-bit LED result bus. Throughput is one instruction per 9 cycles.

## Interface
Parameters:
- `DATA_W`, default 8: datapath width; also the number of shift cycles.
- `NREGS`, default 4: register-file depth. Addressed by 2-bit fields.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: **synchronous, active-high** reset.
- `start`, in, 1: one-cycle pulse; the instruction is valid in this cycle.
- `opcode`, in, 4: operation code.
- `instr`, in, 12: `[11:10]` = rd, `[9:8]` = rs, `[7:0]` = imm.
- `busy`, out, 1: an instruction is in flight.
- `done`, out, 1: one-cycle pulse marking retirement.
- `out_result`, out, 8: LED value, written only by OUT.
- `flag_z`, out, 1: zero flag.
- `flag_c`, out, 1: carry flag (no-borrow for SUB).

## Operation
- Opcodes:
  - 0 NOP.
  - 1 LDI: rd ← imm.
  - 2 ADD: rd ← rd + rs.
  - 3 SUB: rd ← rd − rs, computed as rd + ~rs + 1.
  - 4 AND, 5 OR, 6 XOR: rd ← rd op rs.
  - 7 ADDI: rd ← rd + imm.
  - 8 SHL: rd ← rd + rd.
  - 9 MOV: rd ← rs.
  - A OUT: out_result ← rd.
  - B–F: reserved; behave as NOP.
- FSM states:
  - IDLE: `start` captures opcode, rd, rs and imm, and loads operand shift registers A and B from the register file/imm; go to SHIFT with count = 0.
  - SHIFT: each cycle, the slice combines A[0], B[0] and the carry flop. The result bit shifts into the MSB of shift register R; A and B shift right; count increments. Count = DATA_W−1 goes to WB.
  - WB: write R to rd (LDI, ADD, SUB, AND, OR, XOR, ADDI, SHL, MOV); update out_result (OUT); update flags; assert done; go to IDLE.
- Carry flop initial value: 1 for SUB, 0 otherwise. Carry out = carry flop value after the last bit.
- Flags:
  - Updated only by ADD, SUB, ADDI, SHL (Z = R==0, C = carry out) and by AND, OR, XOR (Z = R==0, C = 0).
  - Unchanged by LDI, MOV, OUT, NOP and reserved opcodes.
- Modular 8-bit arithmetic; no saturation.
- `start` is ignored while `busy` = 1. opcode and instr are sampled only on the accepting edge.
- rd = rs is legal: operands are captured before writeback.

## Timing
- Reset values: busy 0, done 0, out_result 0x00, flag_z 0, flag_c 0, all registers 0x00, state IDLE, count 0.
- Edge numbering: the accepting edge is E0.
  - busy = 1 from E0 until E9 (combinational from state ≠ IDLE).
  - SHIFT occupies E1–E8; WB is evaluated at E9.
  - done is a registered pulse, high for exactly the one cycle after E9.
  - Writeback, flags and out_result all become visible in that same cycle.
- Start-to-done latency is 9 cycles for every opcode, including NOP and reserved.
- A `start` in the done cycle is accepted (busy = 0 then): back-to-back rate of one instruction per 9 cycles.
- Reset mid-operation: return to IDLE at the next edge with no writeback and no done. All registers and outputs return to reset values.
- A `start` coincident with `rst` is dropped.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode localparams (OP_NOP … OP_OUT);
  - FSM state encoding (IDLE, SHIFT, WB);
  - field-position constants for rd, rs and imm;
  - DATA_W default.
- Sub-module `serial_alu_slice` (combinational):
  - inputs: a, b, cin, opcode;
  - outputs: r, cout;
  - B-inversion for SUB is done inside the slice.
- Shift registers, counter, register file and FSM live in `serial_exec_unit`.

## Test plan
- Reset: hold rst for 2 cycles, then check busy = 0, done = 0, out_result = 0x00, Z = C = 0. Issue OUT r3 (opcode A, instr 0xC00) → out_result 0x00.
- LDI r1,0x5A (opcode 1, instr 0x45A), then OUT r1 (opcode A, instr 0x400) → done exactly 9 cycles after each start; out_result = 0x5A; flags unchanged.
- ADD carry: LDI r0,0xF0; LDI r1,0x20; ADD r0,r1 (opcode 2, instr 0x100) → r0 = 0x10, C = 1, Z = 0. Then SHL r0 (opcode 8, instr 0x000) → r0 = 0x20, C = 0.
- SUB equal: LDI r2,0x33; LDI r3,0x33; SUB r2,r3 (opcode 3, instr 0xB00) → r2 = 0x00, Z = 1, C = 1. Then SUB r1(0x20),r3 → 0xED, C = 0.
- Handshake:
  - start pulses at cycles 3 and 6 after acceptance → both ignored, exactly one done;
  - start in the done cycle → accepted; the next done follows 9 cycles later.
- Reset mid-op: assert rst at E4 of ADD r0,r1 → no done; r0 = 0x00; busy = 0 at the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the bit-serial execution stage: opcodes, instruction
// field positions, FSM encoding and opcode-class helpers.
package cpu_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_MOV  = 4'h9;
  localparam logic [3:0] OP_OUT  = 4'hA;

  localparam int unsigned REG_AW  = 2;
  localparam int unsigned RD_LSB  = 10;
  localparam int unsigned RS_LSB  = 8;
  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned IMM_W   = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StWb    = 2'd2
  } state_e;

  function automatic logic op_writes_rd(input logic [3:0] op);
    logic w;
    case (op)
      OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_ADDI, OP_SHL, OP_MOV: w = 1'b1;
      default:                 w = 1'b0;
    endcase
    return w;
  endfunction

  function automatic logic op_arith_flags(input logic [3:0] op);
    logic f;
    case (op)
      OP_ADD, OP_SUB, OP_ADDI, OP_SHL: f = 1'b1;
      default:                         f = 1'b0;
    endcase
    return f;
  endfunction

  function automatic logic op_logic_flags(input logic [3:0] op);
    logic f;
    case (op)
      OP_AND, OP_OR, OP_XOR: f = 1'b1;
      default:               f = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/serial_alu_slice.sv
// One-bit ALU slice evaluated once per shift cycle; SUB inverts b here so the
// caller only has to seed the carry with 1.
module serial_alu_slice
  import cpu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [3:0] opcode,
  output logic       r,
  output logic       cout
);

  logic b_eff;

  always_comb begin
    b_eff = (opcode == OP_SUB) ? ~b : b;
    r     = 1'b0;
    cout  = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_ADDI, OP_SHL: begin
        r    = a ^ b_eff ^ cin;
        cout = (a & b_eff) | (a & cin) | (b_eff & cin);
      end
      OP_AND:         r = a & b;
      OP_OR:          r = a | b;
      OP_XOR:         r = a ^ b;
      OP_LDI, OP_MOV: r = b;
      OP_OUT:         r = a;
      default:        r = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_exec_unit.sv
// Bit-serial execution stage: captures one instruction on start, shifts it
// LSB-first through a 1-bit ALU slice, then writes back in a single cycle.
module serial_exec_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned NREGS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        opcode,
  input  logic [11:0]       instr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] out_result,
  output logic              flag_z,
  output logic              flag_c
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  state_e state_q, state_d;

  logic [CntW-1:0]   count_q;
  logic [3:0]        op_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] a_q, b_q, r_q;
  logic              carry_q;
  logic              done_q;
  logic [DATA_W-1:0] out_q;
  logic              z_q, c_q;
  logic [DATA_W-1:0] regs_q [NREGS];

  logic [REG_AW-1:0] rd_f, rs_f;
  logic [IMM_W-1:0]  imm_f;
  logic [DATA_W-1:0] b_sel;
  logic              r_bit, cout_bit;

  assign rd_f  = instr[RD_LSB +: REG_AW];
  assign rs_f  = instr[RS_LSB +: REG_AW];
  assign imm_f = instr[IMM_LSB +: IMM_W];

  // B carries the second operand; SHL doubles rd by adding it to itself.
  always_comb begin
    b_sel = regs_q[rs_f];
    if (opcode == OP_LDI || opcode == OP_ADDI) begin
      b_sel = DATA_W'(imm_f);
    end else if (opcode == OP_SHL) begin
      b_sel = regs_q[rd_f];
    end
  end

  serial_alu_slice u_slice (
    .a      (a_q[0]),
    .b      (b_q[0]),
    .cin    (carry_q),
    .opcode (op_q),
    .r      (r_bit),
    .cout   (cout_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (count_q == CntLast) state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      op_q    <= OP_NOP;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      done_q <= (state_q == StWb);
      case (state_q)
        StIdle: begin
          if (start) begin
            op_q    <= opcode;
            rd_q    <= rd_f;
            a_q     <= regs_q[rd_f];
            b_q     <= b_sel;
            r_q     <= '0;
            carry_q <= (opcode == OP_SUB);
            count_q <= '0;
          end
        end
        StShift: begin
          r_q     <= {r_bit, r_q[DATA_W-1:1]};
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= cout_bit;
          count_q <= count_q + 1'b1;
        end
        StWb: begin
          if (op_writes_rd(op_q)) begin
            regs_q[rd_q] <= r_q;
          end
          if (op_q == OP_OUT) begin
            out_q <= r_q;
          end
          if (op_arith_flags(op_q)) begin
            z_q <= (r_q == '0);
            c_q <= carry_q;
          end else if (op_logic_flags(op_q)) begin
            z_q <= (r_q == '0);
            c_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign done       = done_q;
  assign out_result = out_q;
  assign flag_z     = z_q;
  assign flag_c     = c_q;

endmodule

// File: tb/tb_serial_exec_unit.sv
// Self-checking bench for serial_exec_unit: a reference model predicts the
// retirement values of each accepted instruction into a scoreboard queue.
module tb_serial_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  opcode;
  logic [11:0] instr;
  logic        busy;
  logic        done;
  logic [7:0]  out_result;
  logic        flag_z;
  logic        flag_c;

  serial_exec_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .opcode     (opcode),
    .instr      (instr),
    .busy       (busy),
    .done       (done),
    .out_result (out_result),
    .flag_z     (flag_z),
    .flag_c     (flag_c)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] out;
    logic       z;
    logic       c;
    int         t0;
    string      tag;
  } exp_t;

  exp_t sbq[$];
  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mreg [4];
  logic       mz, mc;
  logic [7:0] mout;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
    mz = 1'b0;
    mc = 1'b0;
    mout = 8'h00;
  endtask

  task automatic model_exec(input logic [3:0] op, input logic [11:0] ins);
    logic [1:0] rd, rs;
    logic [7:0] imm;
    logic [8:0] s;
    rd  = ins[11:10];
    rs  = ins[9:8];
    imm = ins[7:0];
    s   = 9'd0;
    case (op)
      4'h1: mreg[rd] = imm;
      4'h2, 4'h3, 4'h7, 4'h8: begin
        if (op == 4'h2) s = {1'b0, mreg[rd]} + {1'b0, mreg[rs]};
        if (op == 4'h3) s = {1'b0, mreg[rd]} + {1'b0, ~mreg[rs]} + 9'd1;
        if (op == 4'h7) s = {1'b0, mreg[rd]} + {1'b0, imm};
        if (op == 4'h8) s = {1'b0, mreg[rd]} + {1'b0, mreg[rd]};
        mreg[rd] = s[7:0];
        mz = (s[7:0] == 8'h00);
        mc = s[8];
      end
      4'h4, 4'h5, 4'h6: begin
        if (op == 4'h4) mreg[rd] = mreg[rd] & mreg[rs];
        if (op == 4'h5) mreg[rd] = mreg[rd] | mreg[rs];
        if (op == 4'h6) mreg[rd] = mreg[rd] ^ mreg[rs];
        mz = (mreg[rd] == 8'h00);
        mc = 1'b0;
      end
      4'h9: mreg[rd] = mreg[rs];
      4'hA: mout = mreg[rd];
      default: ;
    endcase
  endtask

  // Waits for an idle cycle, pulses start for one edge, and (if expected to
  // retire) pushes the predicted retirement state.
  task automatic issue(input logic [3:0] op, input logic [11:0] ins, input string tag,
                       input bit retires);
    int waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (busy && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (busy) check_eq({tag, "_idle_timeout"}, {31'd0, busy}, 32'd0);
    opcode = op;
    instr  = ins;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (retires) begin
      model_exec(op, ins);
      e.out = mout;
      e.z   = mz;
      e.c   = mc;
      e.t0  = cyc;
      e.tag = tag;
      sbq.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sbq.size() == 0) begin
        check_eq("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        e = sbq.pop_front();
        check_eq({e.tag, "_out"}, {24'd0, out_result}, {24'd0, e.out});
        check_eq({e.tag, "_z"}, {31'd0, flag_z}, {31'd0, e.z});
        check_eq({e.tag, "_c"}, {31'd0, flag_c}, {31'd0, e.c});
        check_eq({e.tag, "_latency"}, cyc - e.t0, 32'd9);
      end
    end
  end

  initial begin
    int w;
    rst    = 1'b1;
    start  = 1'b0;
    opcode = 4'h0;
    instr  = 12'h000;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_out", {24'd0, out_result}, 32'h00);
    check_eq("rst_z", {31'd0, flag_z}, 32'd0);
    check_eq("rst_c", {31'd0, flag_c}, 32'd0);

    issue(4'hA, 12'hC00, "out_r3_rst", 1'b1);
    issue(4'h1, 12'h45A, "ldi_r1", 1'b1);
    issue(4'hA, 12'h400, "out_r1_5a", 1'b1);

    issue(4'h1, 12'h0F0, "ldi_r0", 1'b1);
    issue(4'h1, 12'h420, "ldi_r1_20", 1'b1);
    issue(4'h2, 12'h100, "add_carry", 1'b1);
    issue(4'hA, 12'h000, "out_r0_10", 1'b1);
    issue(4'h8, 12'h000, "shl_r0", 1'b1);
    issue(4'hA, 12'h000, "out_r0_20", 1'b1);

    issue(4'h1, 12'h833, "ldi_r2", 1'b1);
    issue(4'h1, 12'hC33, "ldi_r3", 1'b1);
    issue(4'h3, 12'hB00, "sub_eq", 1'b1);
    issue(4'hA, 12'h800, "out_r2_00", 1'b1);
    issue(4'h3, 12'h700, "sub_borrow", 1'b1);
    issue(4'hA, 12'h400, "out_r1_ed", 1'b1);

    issue(4'h6, 12'hF00, "xor_self", 1'b1);
    issue(4'h5, 12'h400, "or_r1_r0", 1'b1);
    issue(4'h4, 12'h700, "and_r1_r3", 1'b1);
    issue(4'h9, 12'h900, "mov_r2_r1", 1'b1);
    issue(4'h7, 12'h8F3, "addi_r2", 1'b1);
    issue(4'h0, 12'h8FF, "nop", 1'b1);
    issue(4'hC, 12'h0FF, "reserved_c", 1'b1);
    issue(4'hA, 12'h800, "out_r2", 1'b1);

    // Starts while busy must be ignored; the following issue lands in the done cycle.
    issue(4'h2, 12'h100, "add_hs", 1'b1);
    repeat (2) @(negedge clk);
    opcode = 4'h1;
    instr  = 12'h0FF;
    start  = 1'b1;
    check_eq("hs_busy_a", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    check_eq("hs_busy_b", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    issue(4'hA, 12'h000, "out_b2b", 1'b1);

    // Reset four edges into an ADD: no retirement, state cleared.
    issue(4'h2, 12'h100, "add_abort", 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_done", {31'd0, done}, 32'd0);
    check_eq("midrst_out", {24'd0, out_result}, 32'h00);
    check_eq("midrst_z", {31'd0, flag_z}, 32'd0);
    check_eq("midrst_c", {31'd0, flag_c}, 32'd0);
    model_reset();
    @(negedge clk);
    opcode = 4'h1;
    instr  = 12'h0AA;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    check_eq("rst_start_dropped", {31'd0, busy}, 32'd0);
    repeat (12) @(negedge clk);
    issue(4'hA, 12'h000, "out_r0_after_rst", 1'b1);
    issue(4'hA, 12'h400, "out_r1_after_rst", 1'b1);

    w = 0;
    while (sbq.size() > 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_eq("drain", sbq.size(), 32'd0);
    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
